// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command sequencer driving a 4-bit shift/rotate register
//
// Purpose: accepts a one-cycle command (load value, operation, step count),
// parallel-loads the register once, applies the requested number of shift
// steps, then pulses done. While idle it reloads the register with its own
// contents, because the register has no hold mode.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-high reset, FSM to IDLE
//   start         in   command strobe, sampled only in IDLE
//   op[1:0]       in   00 load only, 01 rotate left, 10 rotate right, 11 ASR
//   count[2:0]    in   number of shift steps, 0-7
//   data[3:0]     in   value parallel-loaded before shifting
//   reg_q[3:0]    in   current register contents
//   par_loadn     out  0 = register loads reg_data
//   rotate_right  out  0 = rotate left
//   as_right      out  with rotate_right=1, arithmetic shift right
//   reg_data[3:0] out  register parallel data
//   busy          out  high outside IDLE
//   done          out  one-cycle pulse, reg_q holds the final result
module shift_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [2:0] count,
  input  logic [3:0] data,
  input  logic [3:0] reg_q,
  output logic       par_loadn,
  output logic       rotate_right,
  output logic       as_right,
  output logic [3:0] reg_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] count_q, count_d;
  logic [3:0] data_q, data_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      count_q <= 3'd0;
      data_q  <= 4'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          count_d = count;
          data_d  = data;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Load-only and zero-step commands skip SHIFT entirely, so the
        // counter is never loaded with zero and cannot underflow.
        if (op_q == 2'b00 || count_q == 3'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = count_q;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        cnt_d = cnt_q - 3'd1;
        // Leaving on cnt_q==1 gives exactly count_q shift edges.
        if (cnt_q == 3'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs: decoded from state and latched command only.
  always_comb begin
    par_loadn    = 1'b0;
    rotate_right = 1'b1;
    as_right     = 1'b0;
    reg_data     = reg_q;
    busy         = 1'b1;
    done         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
      end
      S_LOAD: begin
        reg_data = data_q;
      end
      S_SHIFT: begin
        par_loadn    = 1'b1;
        reg_data     = data_q;
        rotate_right = (op_q != 2'b01);
        as_right     = (op_q == 2'b11);
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [2:0] count;
  logic [3:0] data;
  logic [3:0] reg_q;
  logic       par_loadn;
  logic       rotate_right;
  logic       as_right;
  logic [3:0] reg_data;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  shift_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .count        (count),
    .data         (data),
    .reg_q        (reg_q),
    .par_loadn    (par_loadn),
    .rotate_right (rotate_right),
    .as_right     (as_right),
    .reg_data     (reg_data),
    .busy         (busy),
    .done         (done)
  );

  // The controlled 4-bit shift/rotate register, with its synchronous reset
  // driven from the same reset net.
  always @(posedge clock) begin
    if (reset)                 reg_q <= 4'd0;
    else if (!par_loadn)       reg_q <= reg_data;
    else if (!rotate_right)    reg_q <= {reg_q[2:0], reg_q[3]};
    else if (as_right)         reg_q <= {reg_q[3], reg_q[3:1]};
    else                       reg_q <= {reg_q[0], reg_q[3:1]};
  end

  // Reference model: final register value and latency from plain arithmetic.
  function automatic logic [3:0] ref_result(input int o, input int c, input int d);
    int k;
    int sd;
    if (o == 0 || c == 0) return 4'(d);
    k = c % 4;
    if (o == 1) return 4'(((d << k) | (d >> (4 - k))) & 15);
    if (o == 2) return 4'(((d >> k) | (d << (4 - k))) & 15);
    sd = (d >= 8) ? d - 16 : d;
    return 4'((sd >>> c) & 15);
  endfunction

  function automatic int ref_latency(input int o, input int c);
    return (o == 0 || c == 0) ? 2 : c + 2;
  endfunction

  // Issues one command; reports edges from the sampling edge to done
  // (21 = timed out), reg_q in the done cycle and busy cycle count.
  // inject_at >= 1 pulses a second start at that cycle.
  task automatic issue(input logic [1:0] o, input logic [2:0] c, input logic [3:0] d,
                       input int inject_at, output int lat, output logic [3:0] res,
                       output int busy_n);
    @(negedge clock);
    start = 1'b1; op = o; count = c; data = d;
    @(negedge clock);
    start = 1'b0;
    op = 2'($urandom_range(3)); count = 3'($urandom_range(7)); data = 4'($urandom_range(15));
    lat = 1; busy_n = 0; res = 4'bx;
    while (lat <= 20) begin
      if (busy) busy_n++;
      if (done) begin
        res = reg_q;
        break;
      end
      start = (lat == inject_at);
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'd0; count = 3'd0; data = 4'd0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done: busy=%b done=%b required busy=0 done=0", busy, done);
    end
    checks++;
    if (par_loadn !== 1'b0 || rotate_right !== 1'b1 || as_right !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: par_loadn=%b rotate_right=%b as_right=%b required 0 1 0",
               par_loadn, rotate_right, as_right);
    end
    checks++;
    if (reg_data !== 4'd0 || reg_q !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: reg_data=%b reg_q=%b required 0000 0000", reg_data, reg_q);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_directed(input logic [1:0] o, input logic [2:0] c, input logic [3:0] d,
                               input string name);
    int lat, bn;
    logic [3:0] res;
    issue(o, c, d, 0, lat, res, bn);
    checks++;
    if (lat !== ref_latency(o, c)) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, ref_latency(o, c));
    end
    checks++;
    if (res !== ref_result(o, c, d)) begin
      errors++;
      $display("FAIL %s_result: got %b required %b", name, res, ref_result(o, c, d));
    end
  endtask

  task automatic test_rotr_sequence();
    logic [3:0] exp_seq [4];
    int lat;
    exp_seq[0] = 4'b1101; exp_seq[1] = 4'b1110; exp_seq[2] = 4'b0111; exp_seq[3] = 4'b1011;
    @(negedge clock);
    start = 1'b1; op = 2'b10; count = 3'd4; data = 4'b1011;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (reg_q !== exp_seq[i]) begin
        errors++;
        $display("FAIL rotr_seq%0d: got %b required %b", i, reg_q, exp_seq[i]);
      end
    end
    lat = 0;
    while (!done && lat < 10) begin
      @(negedge clock);
      lat++;
    end
    checks++;
    if (done !== 1'b1 || lat !== 0 || reg_q !== 4'b1011) begin
      errors++;
      $display("FAIL rotr_done: done=%b extra=%0d reg_q=%b required 1 0 1011", done, lat, reg_q);
    end
  endtask

  task automatic test_load_only_hold();
    int lat, bn;
    logic [3:0] res;
    issue(2'b00, 3'($urandom_range(7)), 4'b0101, 0, lat, res, bn);
    checks++;
    if (lat !== 2 || res !== 4'b0101) begin
      errors++;
      $display("FAIL load_only: lat=%0d res=%b required 2 0101", lat, res);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (reg_q !== 4'b0101 || par_loadn !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold%0d: reg_q=%b par_loadn=%b busy=%b required 0101 0 0",
                 i, reg_q, par_loadn, busy);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, bn;
    logic [3:0] res;
    issue(2'b01, 3'd3, 4'b0110, 2, lat, res, bn);
    checks++;
    if (lat !== 5 || res !== 4'b0011 || bn !== 5) begin
      errors++;
      $display("FAIL ignore_start: lat=%0d res=%b busy=%0d required 5 0011 5", lat, res, bn);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL not_queued%0d: busy=%b required 0", i, busy);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat, bn;
    logic [3:0] res;
    logic seen_done;
    @(negedge clock);
    start = 1'b1; op = 2'b01; count = 3'd7; data = 4'b1001;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || par_loadn !== 1'b0 || rotate_right !== 1'b1 ||
        as_right !== 1'b0 || reg_data !== reg_q) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b pl=%b rr=%b asr=%b rd=%b q=%b required 0 0 0 1 0 rd==q",
               busy, done, par_loadn, rotate_right, as_right, reg_data, reg_q);
    end
    @(negedge clock);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (done || busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_no_done: activity=%b required 0", seen_done);
    end
    issue(2'b10, 3'd1, 4'b0001, 0, lat, res, bn);
    checks++;
    if (lat !== 3 || res !== 4'b1000) begin
      errors++;
      $display("FAIL after_reset: lat=%0d res=%b required 3 1000", lat, res);
    end
  endtask

  task automatic test_random();
    int lat, bn;
    logic [3:0] res;
    logic [1:0] o;
    logic [2:0] c;
    logic [3:0] d;
    for (int i = 0; i < 20; i++) begin
      o = 2'($urandom_range(3)); c = 3'($urandom_range(7)); d = 4'($urandom_range(15));
      issue(o, c, d, 0, lat, res, bn);
      checks++;
      if (lat !== ref_latency(o, c) || res !== ref_result(o, c, d) || bn !== lat) begin
        errors++;
        $display("FAIL random%0d op=%0d cnt=%0d d=%b: lat=%0d res=%b busy=%0d required %0d %b %0d",
                 i, o, c, d, lat, res, bn, ref_latency(o, c), ref_result(o, c, d),
                 ref_latency(o, c));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] o [4];
    logic [2:0] c [4];
    logic [3:0] d [4];
    int gap;
    for (int i = 0; i < 4; i++) begin
      o[i] = 2'($urandom_range(3)); c[i] = 3'($urandom_range(7)); d[i] = 4'($urandom_range(15));
    end
    @(negedge clock);
    start = 1'b1; op = o[0]; count = c[0]; data = d[0];
    for (int i = 0; i < 4; i++) begin
      gap = 0;
      do begin
        @(negedge clock);
        gap++;
      end while (!done && gap < 20);
      checks++;
      if (done !== 1'b1 || reg_q !== ref_result(o[i], c[i], d[i]) ||
          gap !== ((i == 0) ? ref_latency(o[i], c[i]) : ref_latency(o[i], c[i]) + 1)) begin
        errors++;
        $display("FAIL b2b%0d: done=%b res=%b gap=%0d required 1 %b %0d", i, done, reg_q, gap,
                 ref_result(o[i], c[i], d[i]),
                 (i == 0) ? ref_latency(o[i], c[i]) : ref_latency(o[i], c[i]) + 1);
      end
      if (i < 3) begin
        op = o[i+1]; count = c[i+1]; data = d[i+1];
      end
    end
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_directed(2'b01, 3'd1, 4'b1011, "rotl1");
    test_rotr_sequence();
    test_directed(2'b11, 3'd2, 4'b1011, "asr2");
    test_directed(2'b11, 3'd7, 4'b1011, "asr7");
    test_directed(2'b01, 3'd4, 4'b1001, "rotl4");
    test_directed(2'b10, 3'd0, 4'b1100, "count0");
    test_load_only_hold();
    test_ignore_start();
    test_reset_mid_shift();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command sequencer for the 4-bit shift/rotate register. It accepts a one-cycle command (load value, operation, step count) and drives the register's parallel-load, rotate-direction and arithmetic-shift controls. It issues one parallel load followed by the requested number of shift steps, then pulses `done`. Between commands it holds the register's contents by reloading them, because the register has no hold mode.

## Interface
- No parameters; data width fixed at 4, step count fixed at 3 bits.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; returns the FSM to IDLE.
- `start`  in  1  command strobe; sampled only in IDLE.
- `op`  in  2  operation: 00 load only, 01 rotate left, 10 rotate right, 11 arithmetic shift right.
- `count`  in  3  number of shift steps, 0–7.
- `data`  in  4  value to parallel-load before shifting.
- `reg_q`  in  4  current register contents (register `Q`).
- `par_loadn`  out  1  to register `ParallelLoadn`; 0 = load `reg_data`.
- `rotate_right`  out  1  to register `RotateRight`; 0 = rotate left.
- `as_right`  out  1  to register `ASRight`; 1 with `rotate_right`=1 gives an arithmetic shift right (MSB held).
- `reg_data`  out  4  to register `Data_IN`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; `reg_q` holds the final result in this cycle.

## Operation
- States: IDLE, LOAD, SHIFT, DONE. Moore outputs, decoded from the state and latched command registers only.
- **IDLE**
  - Outputs: `par_loadn`=0, `reg_data`=`reg_q` (hold), `rotate_right`=1, `as_right`=0.
  - `start`=1 latches `op`, `count` and `data`, then goes to LOAD.
- **LOAD**
  - Outputs: `par_loadn`=0, `reg_data`=latched `data`.
  - Goes to DONE if op=00 or count=0. Otherwise loads the step counter with `count` and goes to SHIFT.
- **SHIFT**
  - `par_loadn`=1. Per op:
    - 01: `rotate_right`=0, `as_right`=0.
    - 10: `rotate_right`=1, `as_right`=0.
    - 11: `rotate_right`=1, `as_right`=1.
  - `reg_data`=latched data (ignored by the register).
  - Counter decrements each cycle. When the counter equals 1, the next state is DONE, so exactly `count` shift edges occur.
- **DONE**
  - Hold outputs as in IDLE; `done`=1; `busy`=1.
  - Unconditionally returns to IDLE.
- `start` in any state other than IDLE is ignored; it is not queued.
- With op=00, `count` is ignored.
- ASR with count≥3 yields full sign fill; rotates by 4 return the original value.
- Counter: 3-bit unsigned; it never underflows because SHIFT is entered only with count≥1.

## Timing
- Reset values (async, immediate):
  - state IDLE; `busy`=0, `done`=0.
  - `par_loadn`=0, `rotate_right`=1, `as_right`=0, `reg_data`=`reg_q`.
  - Latched command registers and counter cleared to 0.
- `start` is sampled at edge E in IDLE:
  - LOAD occupies cycle E+1.
  - SHIFT occupies cycles E+2 … E+1+N.
  - DONE occupies cycle E+2+N.
  - Back in IDLE at E+3+N.
- Latency from `start` edge to `done` is N+2 cycles; load-only or count=0 takes 2 cycles.
- A new `start` is accepted no earlier than the first IDLE cycle after DONE, giving a back-to-back period of N+3 cycles.
- Reset mid-operation: the FSM aborts to IDLE and `done` is not pulsed. The register itself is cleared by its own synchronous reset, driven from the same net at the top level.
- `start` held high continuously re-triggers on each IDLE cycle, using the command inputs present at that edge.

## Test plan
- Reset asserted mid-SHIFT: outputs immediately take their reset values; no `done` pulse; next `start` behaves normally.
- op=01, count=1, data=1011 → `done` 3 cycles after `start`, `reg_q`=0111 in the DONE cycle.
- op=10, count=4, data=1011 → `reg_q` sequence 1101, 1110, 0111, 1011; `done` at cycle 6 with `reg_q`=1011.
- op=11, count=2, data=1011 → 1101 then 1110; `done` with `reg_q`=1110. Repeat with count=7 → 1111.
- op=00, data=0101, followed by 10 idle cycles → `done` at cycle 2; `reg_q` stays 0101 throughout idle; `par_loadn`=0 while idle.
- `start` pulsed during SHIFT (op=01, count=3, data=0110) → second command ignored; result 0011; `busy` high for exactly 5 cycles.
